instr_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB over a shared single-port memory with a req/ready handshake. It drives the instruction-register latch, PC update, register-file write and ALU operand muxes, and selects the immediate format for the immediate generator. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/instr_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for an RV32I core.
// Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB over a
// shared single-port memory that uses a req/ready handshake.
//
// Parameters
//   MEM_TIMEOUT  max consecutive wait cycles per memory request (0 = no timeout)
//   CNT_W        width of the retired-instruction counter
// Inputs
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   instr              instruction register contents, valid from DECODE onward
//   mem_ready          memory completes the current request this cycle
//   branch_taken       comparator result, used in EXEC for branches
// Outputs
//   mem_req, mem_we, addr_sel          memory request, store, address source
//   ir_en, pc_en, pc_src               IR latch, PC update and PC source
//   reg_we, wb_sel                     register write enable and source
//   alu_a_sel, alu_b_sel, imm_sel      ALU operand muxes, immediate format
//   trap, trap_cause                   sticky fault flag and its cause
//   instret                            retired-instruction count
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StRst, StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [3:0] {
    OpIllegal, OpReg, OpImm, OpLoad, OpStore, OpBranch, OpLui, OpAuipc, OpJal, OpJalr
  } op_e;

  localparam logic [31:0] WaitLast  = 32'(MEM_TIMEOUT - 1);
  localparam bit          TimeoutEn = (MEM_TIMEOUT != 0);

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseIllegal = 2'd1;
  localparam logic [1:0] CauseTimeout = 2'd2;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               shamt_q, shamt_d;
  logic [31:0]        wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  op_e                dec_op;
  logic               dec_shamt;
  op_e                cur_op;
  logic               cur_shamt;
  logic               timeout;
  logic               retire;
  logic               show_dec;

  // Only opcode and funct3 steer control; the remaining IR bits feed the datapath.
  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  // Opcode decode of the live IR.
  always_comb begin
    dec_op = OpIllegal;
    unique case (instr[6:0])
      7'b0110011: dec_op = OpReg;
      7'b0010011: dec_op = OpImm;
      7'b0000011: dec_op = OpLoad;
      7'b0100011: dec_op = OpStore;
      7'b1100011: dec_op = OpBranch;
      7'b0110111: dec_op = OpLui;
      7'b0010111: dec_op = OpAuipc;
      7'b1101111: dec_op = OpJal;
      7'b1100111: dec_op = OpJalr;
      default:    dec_op = OpIllegal;
    endcase
    dec_shamt = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
  end

  // DECODE uses the live decode; later states use the copy latched at its end.
  assign cur_op    = (state_q == StDecode) ? dec_op : op_q;
  assign cur_shamt = (state_q == StDecode) ? dec_shamt : shamt_q;
  assign show_dec  = (state_q == StDecode) || (state_q == StExec) ||
                     (state_q == StMem)    || (state_q == StWb);
  assign timeout   = TimeoutEn && !mem_ready && (wait_q == WaitLast);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shamt_d   = shamt_q;
    wait_d    = wait_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    retire    = 1'b0;
    case (state_q)
      StRst: begin
        state_d = StFetch;
        wait_d  = '0;
      end
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StDecode: begin
        op_d    = dec_op;
        shamt_d = dec_shamt;
        if (dec_op == OpIllegal) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if ((op_q == OpLoad) || (op_q == OpStore)) begin
          state_d = StMem;
          wait_d  = '0;
        end else if (op_q == OpBranch) begin
          state_d = StFetch;
          wait_d  = '0;
          retire  = 1'b1;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (op_q == OpLoad) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            wait_d  = '0;
            retire  = 1'b1;
          end
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      StWb: begin
        state_d = StFetch;
        wait_d  = '0;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StRst;
    endcase
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRst;
      op_q      <= OpIllegal;
      shamt_q   <= 1'b0;
      wait_q    <= '0;
      cause_q   <= CauseNone;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shamt_q   <= shamt_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Outputs: functions of the registered state and decode; only ir_en and pc_en
  // look at mem_ready, and only in a memory completion cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    imm_sel   = 3'd0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_en   = mem_ready;
      end
      StExec: begin
        pc_en = (op_q == OpBranch);
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_q == OpStore);
        pc_en    = mem_ready && (op_q == OpStore);
      end
      StWb: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (show_dec) begin
      alu_a_sel = (cur_op == OpAuipc);
      alu_b_sel = !((cur_op == OpReg) || (cur_op == OpBranch) || (cur_op == OpIllegal));
      case (cur_op)
        OpImm:          imm_sel = cur_shamt ? 3'd5 : 3'd0;
        OpStore:        imm_sel = 3'd1;
        OpBranch:       imm_sel = 3'd2;
        OpLui, OpAuipc: imm_sel = 3'd3;
        OpJal:          imm_sel = 3'd4;
        default:        imm_sel = 3'd0;
      endcase
      case (cur_op)
        OpLoad:        wb_sel = 2'd1;
        OpJal, OpJalr: wb_sel = 2'd2;
        OpLui:         wb_sel = 2'd3;
        default:       wb_sel = 2'd0;
      endcase
      if ((state_q == StExec) && (cur_op == OpBranch)) begin
        pc_src = {1'b0, branch_taken};
      end else if (cur_op == OpJal) begin
        pc_src = 2'd1;
      end else if (cur_op == OpJalr) begin
        pc_src = 2'd2;
      end else begin
        pc_src = 2'd0;
      end
    end
  end

  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer (MEM_TIMEOUT=4, CNT_W=4 so the counter wraps).
// The reference model expands each instruction into its expected per-cycle
// control trace from the opcode rules, then steps the DUT through it.
module tb_instr_sequencer;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] imm_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    int          fw;
    int          mw;
    logic        tk;
    int          cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_en, pc_en, reg_we;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic        alu_a_sel, alu_b_sel, trap;
  logic [2:0]  imm_sel;
  logic [3:0]  instret;
  out_t        act;

  instr_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .mem_ready   (mem_ready),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .imm_sel     (imm_sel),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src, reg_we, wb_sel,
                alu_a_sel, alu_b_sel, imm_sel, trap, trap_cause};

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_instret = '0;
  int         cyc;
  int         pc_at;

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Decoded control fields per opcode; kind: 0 illegal, 1 ALU/jump with WB,
  // 2 load, 3 store, 4 branch.
  function automatic out_t ref_dec(input logic [31:0] ins, output int kind);
    out_t o;
    logic [2:0] f3;
    o = '0;
    kind = 0;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: kind = 1;
      7'h13: begin kind = 1; o.alu_b_sel = 1; o.imm_sel = (f3 == 1 || f3 == 5) ? 3'd5 : 3'd0; end
      7'h03: begin kind = 2; o.alu_b_sel = 1; o.wb_sel = 2'd1; end
      7'h23: begin kind = 3; o.alu_b_sel = 1; o.imm_sel = 3'd1; end
      7'h63: begin kind = 4; o.imm_sel = 3'd2; end
      7'h37: begin kind = 1; o.alu_b_sel = 1; o.imm_sel = 3'd3; o.wb_sel = 2'd3; end
      7'h17: begin kind = 1; o.alu_a_sel = 1; o.alu_b_sel = 1; o.imm_sel = 3'd3; end
      7'h6F: begin
        kind = 1; o.alu_b_sel = 1; o.imm_sel = 3'd4; o.wb_sel = 2'd2; o.pc_src = 2'd1;
      end
      7'h67: begin kind = 1; o.alu_b_sel = 1; o.wb_sel = 2'd2; o.pc_src = 2'd2; end
      default: kind = 0;
    endcase
    return o;
  endfunction

  task automatic check(input out_t exp, input string nm);
    vectors++;
    if (act !== exp || instret !== exp_instret) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): outs got %h want %h, instret got %0d want %0d",
               nm, cyc, act, exp, instret, exp_instret);
    end
  endtask

  // One clock cycle: drive inputs, compare, advance past the rising edge.
  task automatic step(input logic rdy, input logic tk, input out_t exp, input bit retire,
                      input string nm);
    mem_ready    = rdy;
    branch_taken = tk;
    #1;
    check(exp, nm);
    cyc++;
    if (act.pc_en && pc_at == 0) pc_at = cyc;
    @(posedge clk);
    #1;
    if (retire) exp_instret = exp_instret + 4'd1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = rnd();
    #1;
    exp_instret = '0;
    check('0, "reset_async");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(rnd(), rnd(), '0, 0, "rst_state");
  endtask

  task automatic trap_hold(input int n, input logic [1:0] cause);
    out_t t;
    t = '0;
    t.trap = 1'b1;
    t.trap_cause = cause;
    for (int i = 0; i < n; i++) step(rnd(), rnd(), t, 0, "trap_hold");
  endtask

  // Runs one instruction; tc returns 0 normal, 1/2 trap cause, 3 aborted in MEM.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic tk,
                           input bit abort_mem, output int tc);
    out_t d, e;
    int   kind;
    d = ref_dec(ins, kind);
    cyc = 0;
    pc_at = 0;
    tc = 0;
    instr = $urandom;
    e = '0;
    e.mem_req = 1'b1;
    for (int w = 0; w < fw && w < 4; w++) step(1'b0, rnd(), e, 0, "fetch_wait");
    if (fw >= 4) begin tc = 2; return; end
    e.ir_en = 1'b1;
    step(1'b1, rnd(), e, 0, "fetch_done");
    instr = ins;
    step(rnd(), rnd(), d, 0, "decode");
    if (kind == 0) begin tc = 1; return; end
    if (kind == 4) begin
      e = d;
      e.pc_en = 1'b1;
      e.pc_src = {1'b0, tk};
      step(rnd(), tk, e, 1, "exec_branch");
      return;
    end
    step(rnd(), rnd(), d, 0, "exec");
    if (kind == 2 || kind == 3) begin
      e = d;
      e.mem_req = 1'b1;
      e.addr_sel = 1'b1;
      e.mem_we = (kind == 3);
      for (int w = 0; w < mw && w < 4; w++) begin
        step(1'b0, rnd(), e, 0, "mem_wait");
        if (abort_mem) begin tc = 3; return; end
      end
      if (mw >= 4) begin tc = 2; return; end
      e.pc_en = (kind == 3);
      step(1'b1, rnd(), e, kind == 3, "mem_done");
      if (kind == 3) return;
    end
    e = d;
    e.reg_we = 1'b1;
    e.pc_en = 1'b1;
    step(rnd(), rnd(), e, 1, "wb");
  endtask

  vec_t        tbl[14];
  logic [6:0]  opcs[9];

  initial begin
    int          tc;
    logic [31:0] ins;
    int          fw, mw;

    tbl[0]  = '{32'h00500093, 0, 0, 1'b0, 4};  // addi x1,x0,5
    tbl[1]  = '{32'h00309093, 0, 0, 1'b0, 4};  // slli
    tbl[2]  = '{32'h4030D093, 0, 0, 1'b0, 4};  // srai
    tbl[3]  = '{32'h00002103, 0, 3, 1'b0, 8};  // lw, ready in last allowed MEM cycle
    tbl[4]  = '{32'h00000463, 0, 0, 1'b1, 3};  // beq taken
    tbl[5]  = '{32'h00000463, 0, 0, 1'b0, 3};  // beq not taken
    tbl[6]  = '{32'h00102023, 0, 0, 1'b0, 4};  // sw
    tbl[7]  = '{32'h00102023, 0, 3, 1'b0, 7};  // sw with 3 waits
    tbl[8]  = '{32'h008000EF, 0, 0, 1'b0, 4};  // jal
    tbl[9]  = '{32'h000100E7, 0, 0, 1'b0, 4};  // jalr
    tbl[10] = '{32'h000011B7, 0, 0, 1'b0, 4};  // lui
    tbl[11] = '{32'h00001217, 0, 0, 1'b0, 4};  // auipc
    tbl[12] = '{32'h002082B3, 2, 0, 1'b0, 6};  // add, 2 fetch waits
    tbl[13] = '{32'h00002103, 3, 0, 1'b0, 8};  // lw, ready in last allowed FETCH cycle
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    do_reset();

    // Enough retires to wrap the 4-bit counter.
    for (int i = 0; i < 18; i++) run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, tc);

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].ins, tbl[i].fw, tbl[i].mw, tbl[i].tk, 1'b0, tc);
      vectors++;
      if (tc != 0 || pc_at != tbl[i].cycles) begin
        miscompares++;
        $display("FAIL cycles[%0d]: got %0d (trap %0d) want %0d", i, pc_at, tc, tbl[i].cycles);
      end
    end

    // Illegal opcode: sticky trap, then recovery through reset.
    run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, tc);
    trap_hold(100, 2'd1);
    do_reset();

    // Memory timeout in MEM and in FETCH.
    run_instr(32'h00002103, 0, 4, 1'b0, 1'b0, tc);
    trap_hold(5, 2'd2);
    do_reset();
    run_instr(32'h00500093, 4, 0, 1'b0, 1'b0, tc);
    trap_hold(3, 2'd2);
    do_reset();

    // Reset while a load waits in MEM.
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, tc);
    run_instr(32'h00002103, 0, 2, 1'b0, 1'b1, tc);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 19) == 0) ins[6:0] = 7'($urandom);
      else ins[6:0] = opcs[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 99) < 3) ? 4 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 99) < 3) ? 4 : int'($urandom_range(0, 3));
      run_instr(ins, fw, mw, rnd(), 1'b0, tc);
      if (tc != 0) begin
        trap_hold(int'($urandom_range(1, 4)), 2'(tc));
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
